// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - strobe/data inputs and channel outputs of the serial demultiplexer
interface stream_demux_if #(
  parameter int DATA_W = 8
) ();
  logic              bit_en;
  logic              ser_in;
  logic              frame_start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] ch1;
  logic [DATA_W-1:0] ch2;
  logic [DATA_W-1:0] ch3;
  logic [2:0]        ch_valid;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  // Upstream serialiser side
  modport master (
    output bit_en, ser_in, frame_start, mode,
    input  ch1, ch2, ch3, ch_valid, frame_done, frame_err, busy
  );

  // Demultiplexer side
  modport slave (
    input  bit_en, ser_in, frame_start, mode,
    output ch1, ch2, ch3, ch_valid, frame_done, frame_err, busy
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - serial-to-parallel demux steering MSB-first words to up to three channels
// Optional feature macro: STREAM_DEMUX_PARITY_EN (one even-parity bit after every word).
module stream_demux #(
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst,
  stream_demux_if.slave dmx
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        n_ch_q, n_ch_d;
  logic [1:0]        word_idx_q, word_idx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] ch1_q, ch1_d;
  logic [DATA_W-1:0] ch2_q, ch2_d;
  logic [DATA_W-1:0] ch3_q, ch3_d;
  logic [2:0]        ch_valid_q, ch_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;

  logic              start;
  logic [DATA_W-1:0] shift_in;
  logic              word_end;
  logic [DATA_W-1:0] word;
  logic              word_ok;

  assign start    = dmx.bit_en & dmx.frame_start;
  assign shift_in = {shreg_q[DATA_W-2:0], dmx.ser_in};

`ifdef STREAM_DEMUX_PARITY_EN
  // The strobe after the last data bit carries parity; the word is already in shreg.
  assign word_end = (bit_cnt_q == CNT_W'(DATA_W));
  assign word     = shreg_q;
  assign word_ok  = ~(^shreg_q ^ dmx.ser_in);
`else
  // The last data bit itself completes the word, so store the shifted value directly.
  assign word_end = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign word     = shift_in;
  assign word_ok  = 1'b1;
`endif

  // Next-state, datapath and pulse generation
  always_comb begin
    state_d      = state_q;
    n_ch_d       = n_ch_q;
    word_idx_d   = word_idx_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    ch1_d        = ch1_q;
    ch2_d        = ch2_q;
    ch3_d        = ch3_q;
    ch_valid_d   = 3'b000;
    frame_err_d  = 1'b0;
    frame_done_d = (state_q == DONE);

    case (state_q)
      SHIFT: begin
        if (start) begin
          // Unexpected frame start: drop the rest of this frame
          frame_err_d = 1'b1;
          word_idx_d  = 2'd0;
          if (dmx.mode != 2'd0) begin
            n_ch_d    = dmx.mode;
            shreg_d   = shift_in;
            bit_cnt_d = CNT_W'(1);
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end
        end else if (dmx.bit_en) begin
          if (word_end) begin
            bit_cnt_d  = '0;
            word_idx_d = word_idx_q + 2'd1;
            if (word_ok) begin
              case (word_idx_q)
                2'd0:    ch1_d = word;
                2'd1:    ch2_d = word;
                default: ch3_d = word;
              endcase
              ch_valid_d = 3'b001 << word_idx_q;
            end else begin
              frame_err_d = 1'b1;
            end
            if (word_idx_q + 2'd1 == n_ch_q) begin
              state_d = DONE;
            end
          end else begin
            shreg_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new frame start
        state_d = IDLE;
        if (start && dmx.mode != 2'd0) begin
          state_d    = SHIFT;
          n_ch_d     = dmx.mode;
          shreg_d    = shift_in;
          bit_cnt_d  = CNT_W'(1);
          word_idx_d = 2'd0;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_ch_q       <= 2'd0;
      word_idx_q   <= 2'd0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      ch1_q        <= '0;
      ch2_q        <= '0;
      ch3_q        <= '0;
      ch_valid_q   <= 3'b000;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_ch_q       <= n_ch_d;
      word_idx_q   <= word_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      ch1_q        <= ch1_d;
      ch2_q        <= ch2_d;
      ch3_q        <= ch3_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dmx.ch1        = ch1_q;
  assign dmx.ch2        = ch2_q;
  assign dmx.ch3        = ch3_q;
  assign dmx.ch_valid   = ch_valid_q;
  assign dmx.frame_done = frame_done_q;
  assign dmx.frame_err  = frame_err_q;
  assign dmx.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux
module tb_stream_demux;
`ifdef STREAM_DEMUX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int         idx;
    logic [7:0] val;
  } sb_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] b0, b1, b2;
    int         gap;
    logic [7:0] e1, e2, e3;
    int         e_done;
    bit         e_busy;
  } vec_t;

  logic clk;
  logic rst;
  stream_demux_if #(.DATA_W(8)) dmx_if ();

  stream_demux #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .dmx (dmx_if.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  bit   busy_seen = 0;
  sb_t  sb[$];
  sb_t  e;
  vec_t vecs[6];
  int   d0, r0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ch_of(input int idx);
    case (idx)
      0:       return dmx_if.ch1;
      1:       return dmx_if.ch2;
      default: return dmx_if.ch3;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every channel write, counts pulses
  always @(negedge clk) begin
    if (dmx_if.frame_done) done_cnt++;
    if (dmx_if.frame_err) err_cnt++;
    if (dmx_if.busy) busy_seen = 1'b1;
    if (dmx_if.ch_valid != 3'b000) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ch_valid", 32'(dmx_if.ch_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ch_valid", 32'(dmx_if.ch_valid), 32'(3'b001 << e.idx));
        chk("sb_ch_data", 32'(ch_of(e.idx)), 32'(e.val));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic fs, input int gap);
    dmx_if.bit_en      = 1'b1;
    dmx_if.ser_in      = b;
    dmx_if.frame_start = fs;
    step(1);
    dmx_if.bit_en      = 1'b0;
    dmx_if.frame_start = 1'b0;
    step(gap);
  endtask

  task automatic send_partial(input logic [7:0] v, input int nbits, input logic fs, input int gap);
    for (int i = 0; i < nbits; i++) send_bit(v[7-i], fs && (i == 0), gap);
  endtask

  task automatic send_par(input logic [7:0] v, input bit bad, input int gap);
    if (PAR_EN) send_bit((^v) ^ bad, 1'b0, gap);
  endtask

  task automatic send_word(input logic [7:0] v, input logic fs, input int gap, input bit bad);
    send_partial(v, 8, fs, gap);
    send_par(v, bad, gap);
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int gap);
    logic [7:0] bytes [3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    dmx_if.mode = m;
    if (m == 2'd0) send_word(b0, 1'b1, gap, 1'b0);
    for (int i = 0; i < int'(m); i++) begin
      sb.push_back('{idx: i, val: bytes[i]});
      send_word(bytes[i], i == 0, gap, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{mode: 2'd1, b0: 8'hA5, b1: 8'h00, b2: 8'h00, gap: 0,  e1: 8'hA5, e2: 8'h00, e3: 8'h00, e_done: 1, e_busy: 1};
    vecs[1] = '{mode: 2'd3, b0: 8'h12, b1: 8'h34, b2: 8'h56, gap: 49, e1: 8'h12, e2: 8'h34, e3: 8'h56, e_done: 1, e_busy: 1};
    vecs[2] = '{mode: 2'd2, b0: 8'hFF, b1: 8'h00, b2: 8'h99, gap: 0,  e1: 8'hFF, e2: 8'h00, e3: 8'h56, e_done: 1, e_busy: 1};
    vecs[3] = '{mode: 2'd0, b0: 8'hAA, b1: 8'h00, b2: 8'h00, gap: 0,  e1: 8'hFF, e2: 8'h00, e3: 8'h56, e_done: 0, e_busy: 0};
    vecs[4] = '{mode: 2'd3, b0: 8'h01, b1: 8'h80, b2: 8'hC3, gap: 2,  e1: 8'h01, e2: 8'h80, e3: 8'hC3, e_done: 1, e_busy: 1};
    vecs[5] = '{mode: 2'd1, b0: 8'h7E, b1: 8'h00, b2: 8'h00, gap: 1,  e1: 8'h7E, e2: 8'h80, e3: 8'hC3, e_done: 1, e_busy: 1};

    rst = 1'b1;
    dmx_if.bit_en = 1'b0;
    dmx_if.ser_in = 1'b0;
    dmx_if.frame_start = 1'b0;
    dmx_if.mode = 2'd0;
    step(3);
    chk("rst_ch1", 32'(dmx_if.ch1), 32'd0);
    chk("rst_ch2", 32'(dmx_if.ch2), 32'd0);
    chk("rst_ch3", 32'(dmx_if.ch3), 32'd0);
    chk("rst_ch_valid", 32'(dmx_if.ch_valid), 32'd0);
    chk("rst_frame_done", 32'(dmx_if.frame_done), 32'd0);
    chk("rst_frame_err", 32'(dmx_if.frame_err), 32'd0);
    chk("rst_busy", 32'(dmx_if.busy), 32'd0);
    rst = 1'b0;
    step(1);

    // Exact latency of a back-to-back single-channel frame
    dmx_if.mode = 2'd1;
    sb.push_back('{idx: 0, val: 8'hA5});
    send_word(8'hA5, 1'b1, 0, 1'b0);
    chk("lat_ch_valid", 32'(dmx_if.ch_valid), 32'h1);
    chk("lat_ch1", 32'(dmx_if.ch1), 32'hA5);
    chk("lat_busy_hi", 32'(dmx_if.busy), 32'd1);
    chk("lat_done_early", 32'(dmx_if.frame_done), 32'd0);
    step(1);
    chk("lat_ch_valid_off", 32'(dmx_if.ch_valid), 32'h0);
    chk("lat_frame_done", 32'(dmx_if.frame_done), 32'd1);
    chk("lat_busy_lo", 32'(dmx_if.busy), 32'd0);
    step(1);
    chk("lat_frame_done_off", 32'(dmx_if.frame_done), 32'd0);

    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt;
      r0 = err_cnt;
      busy_seen = 1'b0;
      send_frame(vecs[k].mode, vecs[k].b0, vecs[k].b1, vecs[k].b2, vecs[k].gap);
      step(3);
      chk($sformatf("vec%0d_ch1", k), 32'(dmx_if.ch1), 32'(vecs[k].e1));
      chk($sformatf("vec%0d_ch2", k), 32'(dmx_if.ch2), 32'(vecs[k].e2));
      chk($sformatf("vec%0d_ch3", k), 32'(dmx_if.ch3), 32'(vecs[k].e3));
      chk($sformatf("vec%0d_done", k), 32'(done_cnt - d0), 32'(vecs[k].e_done));
      chk($sformatf("vec%0d_err", k), 32'(err_cnt - r0), 32'd0);
      chk($sformatf("vec%0d_busy_seen", k), 32'(busy_seen), 32'(vecs[k].e_busy));
      chk($sformatf("vec%0d_busy_end", k), 32'(dmx_if.busy), 32'd0);
    end

    // Frame restart: frame_start arrives after 5 bits of ch2
    d0 = done_cnt;
    r0 = err_cnt;
    dmx_if.mode = 2'd2;
    sb.push_back('{idx: 0, val: 8'h33});
    send_word(8'h33, 1'b1, 0, 1'b0);
    send_partial(8'hAB, 5, 1'b0, 0);
    chk("rst_frame_ch1_kept", 32'(dmx_if.ch1), 32'h33);
    chk("rst_frame_ch2_kept", 32'(dmx_if.ch2), 32'h80);
    chk("rst_frame_no_err_yet", 32'(err_cnt - r0), 32'd0);
    sb.push_back('{idx: 0, val: 8'h44});
    send_word(8'h44, 1'b1, 0, 1'b0);
    chk("restart_err", 32'(err_cnt - r0), 32'd1);
    sb.push_back('{idx: 1, val: 8'h55});
    send_word(8'h55, 1'b0, 0, 1'b0);
    step(3);
    chk("restart_ch1", 32'(dmx_if.ch1), 32'h44);
    chk("restart_ch2", 32'(dmx_if.ch2), 32'h55);
    chk("restart_done", 32'(done_cnt - d0), 32'd1);

    // Mode change mid-frame keeps the latched channel count
    d0 = done_cnt;
    dmx_if.mode = 2'd1;
    sb.push_back('{idx: 0, val: 8'h3C});
    send_partial(8'h3C, 4, 1'b1, 0);
    dmx_if.mode = 2'd3;
    send_partial(8'hC0, 4, 1'b0, 0);
    send_par(8'h3C, 1'b0, 0);
    step(3);
    chk("modechg_ch1", 32'(dmx_if.ch1), 32'h3C);
    chk("modechg_ch2", 32'(dmx_if.ch2), 32'h55);
    chk("modechg_done", 32'(done_cnt - d0), 32'd1);
    chk("modechg_busy", 32'(dmx_if.busy), 32'd0);

    if (PAR_EN) begin
      d0 = done_cnt;
      r0 = err_cnt;
      dmx_if.mode = 2'd2;
      send_word(8'h0F, 1'b1, 0, 1'b1);
      sb.push_back('{idx: 1, val: 8'h01});
      send_word(8'h01, 1'b0, 0, 1'b0);
      step(3);
      chk("par_ch1_kept", 32'(dmx_if.ch1), 32'h3C);
      chk("par_ch2", 32'(dmx_if.ch2), 32'h01);
      chk("par_err", 32'(err_cnt - r0), 32'd1);
      chk("par_done", 32'(done_cnt - d0), 32'd1);
    end

    // Reset in the middle of a three-channel frame
    d0 = done_cnt;
    dmx_if.mode = 2'd3;
    sb.push_back('{idx: 0, val: 8'h12});
    send_word(8'h12, 1'b1, 0, 1'b0);
    send_partial(8'h34, 4, 1'b0, 0);
    rst = 1'b1;
    step(2);
    chk("midrst_ch1", 32'(dmx_if.ch1), 32'd0);
    chk("midrst_ch2", 32'(dmx_if.ch2), 32'd0);
    chk("midrst_ch3", 32'(dmx_if.ch3), 32'd0);
    chk("midrst_busy", 32'(dmx_if.busy), 32'd0);
    chk("midrst_ch_valid", 32'(dmx_if.ch_valid), 32'd0);
    rst = 1'b0;
    step(2);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    dmx_if.mode = 2'd1;
    sb.push_back('{idx: 0, val: 8'h5A});
    send_word(8'h5A, 1'b1, 0, 1'b0);
    step(3);
    chk("postrst_ch1", 32'(dmx_if.ch1), 32'h5A);
    chk("postrst_ch2", 32'(dmx_if.ch2), 32'd0);
    chk("postrst_done", 32'(done_cnt - d0), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
# stream_demux

Serial-to-parallel demultiplexer sitting directly downstream of the serial multiplexing stage. Samples the single-bit multiplexed stream on an upstream bit strobe, deserialises MSB-first bytes and steers them, in order, to up to three channel registers selected by the mode latched at frame start. Flags per-channel arrival, frame completion and framing errors for the consuming logic.

## Interface
- DATA_W, 8, bits per channel word (and per serial byte)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  one-clk strobe marking a valid serial bit; ser_in/frame_start ignored when 0
- ser_in  input  1  multiplexed serial data bit
- frame_start  input  1  qualified by bit_en; marks first bit (MSB of channel 1) of a frame
- mode  input  2  channels per frame: 1 -> ch1; 2 -> ch1,ch2; 3 -> ch1,ch2,ch3; 0 -> receiver disabled
- ch1, ch2, ch3  output  DATA_W  channel registers, hold last good word
- ch_valid  output  3  one-clk pulse, bit i-1 when ch_i updated
- frame_done  output  1  one-clk pulse after last word of a frame stored
- frame_err  output  1  one-clk pulse on framing/parity error
- busy  output  1  high while a frame is in progress

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on bit_en & frame_start & mode!=0 -> latch mode as n_ch, shift ser_in into bit 0 of shift register, bit_cnt=1, word_idx=0, go SHIFT. frame_start with mode==0 is ignored (no error). bit_en without frame_start in IDLE ignored.
- SHIFT: each bit_en shifts ser_in in (MSB first: shreg <= {shreg[DATA_W-2:0], ser_in}), bit_cnt++. When the word's final bit arrives: write word to ch[word_idx+1], pulse ch_valid[word_idx], reset bit_cnt, word_idx++. If word_idx reaches n_ch -> DONE.
- DONE: pulse frame_done for one clk, return IDLE. A bit_en+frame_start coinciding with DONE is accepted as a new frame start (no lost frame).
- frame_start while in SHIFT (with bit_en): pulse frame_err, discard partial word and remaining frame, restart frame with this bit as MSB of ch1 using current mode; already-written channels keep their new values. If current mode==0, abort to IDLE instead.
- mode changes mid-frame have no effect until next frame_start.
- busy = state != IDLE.

## Timing
- Reset values: ch1=ch2=ch3=0, ch_valid=0, frame_done=0, frame_err=0, busy=0, state IDLE, counters 0.
- Reset mid-frame: frame discarded, outputs to reset values on the next clk; no pulses emitted.
- ch_valid[i] and ch_i update on the clk edge registering the bit_en of the word's last bit (1 clk latency from strobe).
- frame_done asserts the clk after the last ch_valid pulse; busy falls with frame_done.
- frame_err asserts the clk edge registering the offending strobe.
- bit_en may be any duty; back-to-back bit_en on consecutive clks must be supported.
- Frame length: n_ch*DATA_W strobes (n_ch*(DATA_W+1) with parity).

## Configuration
- STREAM_DEMUX_PARITY_EN defined: each word followed by one even-parity bit (XOR of word and parity = 0). On mismatch: word not written, ch_valid bit not pulsed, frame_err pulsed, frame continues with next word; frame_done still issued.
- Undefined: no parity bit, words are DATA_W bits back to back; frame_err only from framing.

## Test plan
- Reset: assert rst 2 clks mid-frame -> all outputs 0, busy 0, next frame received cleanly.
- mode=1, frame 0xA5 on consecutive strobes -> ch1=0xA5, ch_valid=3'b001 for 1 clk, frame_done next clk.
- mode=3, bytes 0x12,0x34,0x56 with bit_en every 50 clks -> ch_valid pulses 001,010,100 in order, ch1..3=0x12/0x34/0x56, one frame_done.
- mode=2, frame_start reasserted after 5 bits of ch2 -> frame_err 1 clk, ch1 retains first frame's value until restarted frame writes new ch1/ch2.
- mode=0, frame_start with strobe -> busy stays 0, no pulses; switch mode mid-frame -> current frame uses latched mode.
- Parity build: mode=2, 0x0F with bad parity then 0x01 good -> ch1 unchanged, frame_err pulse, ch2=0x01, ch_valid=010, frame_done.
